// File: rtl/par2ser_pkg.sv
// Shared definitions for the parallel-to-serial converter.
//   state_t    : shifter FSM states
//   cnt_width  : width of the bit counter for a given word width
package par2ser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/par2ser_hold.sv
// One-entry holding buffer in front of the shifter.
//   clk_in, rst          : clock, async active-high reset
//   s_valid/s_data       : upstream word offer
//   s_ready              : buffer empty (held low during reset)
//   hold_pop             : shifter takes the buffered word this edge
//   hold_full/hold_data  : buffered word toward the shifter
module par2ser_hold #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              hold_pop,
  output logic              hold_full,
  output logic [DATA_W-1:0] hold_data
);

  // Capture only looks at the registered flag; the async reset already
  // clears it, so rst gates only the visible ready.
  logic accept;
  assign accept  = s_valid && !hold_full;
  assign s_ready = !hold_full && !rst;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= s_data;
    end else if (hold_pop) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/par2ser_aligned.sv
// Parallel-to-serial converter aligned to the half-rate divider phase.
// Words arrive over valid/ready into a one-entry buffer and are shifted out
// one bit per clk_in cycle; a new stream only starts on a div_phase-high
// cycle, back-to-back words follow with no gap.
//   clk_in, rst        : clock, async active-high reset
//   div_phase          : divider output level, synchronous to clk_in
//   s_valid/s_data     : upstream word, s_ready = buffer empty
//   ser_out            : serial bit (IDLE_BIT when idle)
//   ser_valid          : ser_out carries data
//   ser_sync           : first bit of each word
//   eos                : last bit of a stream with nothing queued behind it
module par2ser_aligned
  import par2ser_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              div_phase,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_sync,
  output logic              eos
);

  localparam int unsigned     CW   = cnt_width(DATA_W);
  localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, src;
  logic              ser_out_d, ser_valid_d, ser_sync_d, eos_d;
  logic              load, hs, full_next;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;

  par2ser_hold #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk_in    (clk_in),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .hold_pop  (load),
    .hold_full (hold_full),
    .hold_data (hold_data)
  );

  assign hs = s_valid && !hold_full;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    load        = 1'b0;
    ser_out_d   = IDLE_BIT;
    src         = sh_q;

    unique case (state_q)
      ST_IDLE: begin
        if (hold_full && div_phase) load = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (hold_full) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    if (load) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      src     = hold_data;
    end

    // sh holds the bits not yet presented; the bit leaving it is the one
    // registered into ser_out for the coming cycle.
    if (state_d == ST_SHIFT) begin
      ser_out_d = MSB_FIRST ? src[DATA_W-1] : src[0];
      sh_d      = MSB_FIRST ? (src << 1) : (src >> 1);
    end

    ser_valid_d = (state_d == ST_SHIFT);
    ser_sync_d  = load;

    // eos is registered, so it is decided on entry to the last bit using the
    // buffer occupancy that will hold during that bit (including a handshake
    // landing on this same edge).
    full_next = (hold_full && !load) || hs;
    eos_d     = (state_d == ST_SHIFT) && (cnt_d == LAST) && !full_next;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      ser_sync  <= 1'b0;
      eos       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      ser_sync  <= ser_sync_d;
      eos       <= eos_d;
    end
  end

endmodule

// File: tb/tb_par2ser_aligned.sv
// Scoreboard bench for par2ser_aligned: one MSB-first and one LSB-first
// instance, expected bit streams pushed at issue time, popped by monitors.
module tb_par2ser_aligned;

  typedef struct packed {
    logic b;
    logic sync;
    logic eos;
  } exp_t;

  logic       clk_in    = 1'b0;
  logic       rst       = 1'b1;
  logic       div_phase = 1'b0;
  logic       s_valid_m = 1'b0;
  logic       s_valid_l = 1'b0;
  logic [7:0] s_data    = '0;
  logic       s_ready_m, ser_out_m, ser_valid_m, ser_sync_m, eos_m;
  logic       s_ready_l, ser_out_l, ser_valid_l, ser_sync_l, eos_l;

  int   total = 0;
  int   bad   = 0;
  exp_t q_m[$];
  exp_t q_l[$];
  exp_t e_m, e_l;
  logic prev_v_m = 1'b0, prev_e_m = 1'b0;
  logic prev_v_l = 1'b0, prev_e_l = 1'b0;

  par2ser_aligned #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk_in(clk_in), .rst(rst), .div_phase(div_phase),
    .s_valid(s_valid_m), .s_data(s_data), .s_ready(s_ready_m),
    .ser_out(ser_out_m), .ser_valid(ser_valid_m), .ser_sync(ser_sync_m), .eos(eos_m)
  );

  par2ser_aligned #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk_in(clk_in), .rst(rst), .div_phase(div_phase),
    .s_valid(s_valid_l), .s_data(s_data), .s_ready(s_ready_l),
    .ser_out(ser_out_l), .ser_valid(ser_valid_l), .ser_sync(ser_sync_l), .eos(eos_l)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clk_in cycle; the divider phase toggles every cycle.
  task automatic step();
    @(posedge clk_in);
    #1;
    div_phase = ~div_phase;
  endtask

  // phase: 0/1 = div_phase level required in the cycle after the handshake,
  // 2 = any. seq lists the expected serial bits left to right.
  task automatic send(input bit lsb, input logic [7:0] d, input logic [7:0] seq,
                      input bit last, input bit push, input int phase);
    int  n = 0;
    exp_t e;
    s_data = d;
    while (!((lsb ? s_ready_l : s_ready_m) &&
             (phase == 2 || div_phase != phase[0])) && n < 100) begin
      step();
      n++;
    end
    check("send_ready_timeout", {7'd0, n >= 100}, 8'd0);
    if (push) begin
      for (int i = 0; i < 8; i++) begin
        e.b    = seq[7-i];
        e.sync = (i == 0);
        e.eos  = last && (i == 7);
        if (lsb) q_l.push_back(e);
        else     q_m.push_back(e);
      end
    end
    if (lsb) s_valid_l = 1'b1;
    else     s_valid_m = 1'b1;
    step();
    s_valid_l = 1'b0;
    s_valid_m = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_m.size() != 0 || q_l.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check("drain_empty", {7'd0, (q_m.size() == 0) && (q_l.size() == 0)}, 8'd1);
    repeat (3) step();
  endtask

  always @(negedge clk_in) begin
    if (rst) begin
      prev_v_m = 1'b0;
      prev_e_m = 1'b0;
    end else begin
      if (ser_valid_m) begin
        check("m_bit_expected", {7'd0, q_m.size() != 0}, 8'd1);
        if (q_m.size() != 0) begin
          e_m = q_m.pop_front();
          check("m_stream", {5'd0, ser_out_m, ser_sync_m, eos_m}, {5'd0, e_m});
          prev_e_m = e_m.eos;
        end
      end else begin
        check("m_idle", {5'd0, ser_out_m, ser_sync_m, eos_m}, 8'd0);
        check("m_gap", {7'd0, prev_v_m && !prev_e_m}, 8'd0);
      end
      prev_v_m = ser_valid_m;
    end
  end

  always @(negedge clk_in) begin
    if (rst) begin
      prev_v_l = 1'b0;
      prev_e_l = 1'b0;
    end else begin
      if (ser_valid_l) begin
        check("l_bit_expected", {7'd0, q_l.size() != 0}, 8'd1);
        if (q_l.size() != 0) begin
          e_l = q_l.pop_front();
          check("l_stream", {5'd0, ser_out_l, ser_sync_l, eos_l}, {5'd0, e_l});
          prev_e_l = e_l.eos;
        end
      end else begin
        check("l_idle", {5'd0, ser_out_l, ser_sync_l, eos_l}, 8'd0);
        check("l_gap", {7'd0, prev_v_l && !prev_e_l}, 8'd0);
      end
      prev_v_l = ser_valid_l;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a word offered: nothing may be captured.
    s_valid_m = 1'b1;
    s_data    = 8'hFF;
    step();
    step();
    check("rst_s_ready",   {7'd0, s_ready_m},   8'd0);
    check("rst_ser_out",   {7'd0, ser_out_m},   8'd0);
    check("rst_ser_valid", {7'd0, ser_valid_m}, 8'd0);
    check("rst_eos",       {7'd0, eos_m},       8'd0);
    s_valid_m = 1'b0;
    rst       = 1'b0;
    #1;
    check("post_rst_s_ready", {7'd0, s_ready_m}, 8'd1);
    repeat (6) step();
    check("post_rst_no_capture", {7'd0, ser_valid_m}, 8'd0);

    // Single word, div_phase high after the handshake: first bit 1 cycle later.
    send(1'b0, 8'hA5, 8'b10100101, 1'b1, 1'b1, 1);
    check("a5_not_yet", {7'd0, ser_valid_m}, 8'd0);
    step();
    check("a5_first_bit", {5'd0, ser_valid_m, ser_sync_m, ser_out_m}, 8'b111);
    drain();

    // Phase wait: div_phase low after the handshake slips the start by 1.
    send(1'b0, 8'h5A, 8'b01011010, 1'b1, 1'b1, 0);
    check("wait_phase_low", {6'd0, div_phase, ser_valid_m}, 8'b00);
    step();
    check("wait_phase_high", {6'd0, div_phase, ser_valid_m}, 8'b10);
    step();
    check("wait_first_bit", {6'd0, ser_valid_m, ser_sync_m}, 8'b11);
    drain();

    // Back-to-back: 24 contiguous bits, eos only on the last.
    send(1'b0, 8'h0F, 8'b00001111, 1'b0, 1'b1, 1);
    send(1'b0, 8'hF0, 8'b11110000, 1'b0, 1'b1, 2);
    send(1'b0, 8'h3C, 8'b00111100, 1'b1, 1'b1, 2);
    drain();

    // LSB first.
    send(1'b1, 8'h01, 8'b10000000, 1'b1, 1'b1, 1);
    drain();

    // Mid-word reset on bit 3 of 0xFF with the buffer holding another word.
    send(1'b0, 8'hFF, 8'b11111111, 1'b0, 1'b1, 1);
    send(1'b0, 8'hFF, 8'b11111111, 1'b0, 1'b0, 2);
    step();
    step();
    check("mid_bit3_valid", {7'd0, ser_valid_m}, 8'd1);
    rst = 1'b1;
    q_m.delete();
    #1;
    check("mid_rst_outputs", {3'd0, ser_out_m, ser_valid_m, ser_sync_m, eos_m, s_ready_m}, 8'd0);
    step();
    rst = 1'b0;
    repeat (20) step();
    check("mid_rst_quiet", {7'd0, ser_valid_m}, 8'd0);
    check("mid_rst_ready", {7'd0, s_ready_m}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/par2ser_aligned.md
# par2ser_aligned

Parallel-to-serial converter that sits directly downstream of the divide-by-2 clock generator in the transmit path. It runs on the fast clock `clk_in`, takes the divider's half-rate phase as a sampled level, and accepts parallel words over a valid/ready handshake. It shifts each word out one bit per `clk_in` cycle, starting every stream only on a divider-phase-high cycle so word boundaries stay aligned to the half-rate clock. A one-word holding buffer gives gapless back-to-back output.

## Interface
- `DATA_W`, default 8: word width. Must be even and at least 2; even width preserves phase alignment across back-to-back words.
- `MSB_FIRST`, default 1: 1 shifts bit `DATA_W-1` first; 0 shifts bit 0 first.
- `IDLE_BIT`, default 0: level driven on `ser_out` when no word is being shifted.

Ports:
- `clk_in`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous, active-high.
- `div_phase`  in  1  divider `clk_out` level, synchronous to `clk_in`.
- `s_valid`  in  1  upstream word valid.
- `s_data`  in  `DATA_W`  upstream word.
- `s_ready`  out  1  holding buffer can accept a word.
- `ser_out`  out  1  serial bit, registered.
- `ser_valid`  out  1  `ser_out` carries a data bit.
- `ser_sync`  out  1  high on the first bit of each word.
- `eos`  out  1  one-cycle pulse on the last bit of a stream, when the buffer is empty.

## Operation
- Holding buffer:
  - Fills on a handshake, i.e. `s_valid && s_ready` at a rising edge.
  - Empties when its word is loaded into the shift register.
  - `s_ready = !hold_full`; forced 0 while `rst` is high.
- States:
  - IDLE: `ser_out = IDLE_BIT`, `ser_valid = 0`.
  - SHIFT: a bit counter runs 0 to `DATA_W-1`.
- Transitions:
  - IDLE to SHIFT: at the edge where `hold_full && div_phase`. Load the shift register from the buffer, clear `hold_full`, counter = 0.
  - IDLE with `hold_full && !div_phase`: stay in IDLE and wait.
  - SHIFT, counter < `DATA_W-1`: increment the counter and shift by one bit.
  - SHIFT, counter = `DATA_W-1`, `hold_full`: reload from the buffer with counter = 0 and no idle gap. `div_phase` is ignored here.
  - SHIFT, counter = `DATA_W-1`, buffer empty: go to IDLE and assert `eos` during that last-bit cycle.
- A handshake and a buffer-to-shift load never coincide, because `s_ready` depends only on registered `hold_full`.
- `ser_sync` is high exactly when the counter = 0 in SHIFT.
- `ser_valid` is high throughout SHIFT.

## Timing
- Reset values:
  - `ser_out = IDLE_BIT`; `ser_valid`, `ser_sync`, `eos` = 0.
  - `s_ready` = 0 while `rst` is high and 1 on the first cycle after release.
  - State IDLE, buffer empty.
- Latency: handshake at edge E0, with `div_phase` = 1 in the following cycle, puts the first bit on `ser_out` after edge E1. That is 1 cycle from handshake to first bit.
- If `div_phase` is 0 after E0, the start slips by exactly 1 cycle, since `div_phase` toggles every cycle.
- Throughput: 1 bit per cycle sustained when upstream refills the buffer within `DATA_W-1` cycles of `s_ready` rising.
- Reset mid-word:
  - The word is aborted and the buffer contents are discarded.
  - Outputs take their reset values immediately, asynchronously.
  - No `eos` is generated.
- All outputs except `s_ready` are registered. `s_ready` is combinational from `hold_full` and `rst` only.

## Structure
- Shared package `par2ser_pkg`:
  - state enum `{ST_IDLE, ST_SHIFT}`;
  - function returning the counter width, `$clog2(DATA_W)`.
- One sub-module, `par2ser_hold`: the 1-entry holding buffer. It has `s_valid`/`s_ready`/`s_data` in, and `hold_full`/`hold_data`/`hold_pop` toward the shifter.

## Test plan
All scenarios use `DATA_W` = 8.
- Reset check: assert `rst` with `s_valid` = 1 and `s_data` = 0xFF -> `s_ready` = 0, `ser_out` = 0, `ser_valid` = 0; nothing is captured after release.
- Single word, `MSB_FIRST` = 1: `s_data` = 0xA5 with `div_phase` high after the handshake -> `ser_out` = 1,0,1,0,0,1,0,1. `ser_sync` is high on the first bit only, `eos` is high on the 8th bit, then `ser_out` returns to `IDLE_BIT`.
- Phase wait: handshake with `div_phase` low in the next cycle -> the first bit is delayed 1 cycle and `ser_sync` coincides with a `div_phase`-high load edge.
- Back-to-back: words 0x0F, 0xF0, 0x3C supplied whenever `s_ready` = 1 -> 24 contiguous bits with `ser_valid` continuously high. `ser_sync` falls on bits 0, 8 and 16, and `eos` fires only on bit 23.
- LSB first: `MSB_FIRST` = 0, `s_data` = 0x01 -> `ser_out` = 1 then seven 0s.
- Mid-word reset: assert `rst` on bit 3 of 0xFF with the buffer full -> outputs go to reset values immediately. After release, with no new input, `ser_valid` stays 0.
